normalize_16bit: RTL and testbench
==================================

Name: normalize_16bit

Overview:
- Sequential normaliser: the inverse companion to the team's combinational 16-bit barrel shifter. Instead of applying a given shift amount, it finds the shift amount.
- Accepts a 16-bit word and a direction. Moves the first set bit to the MSB (left mode) or LSB (right mode). Returns the normalised word, the shift count that was applied, and a zero flag.
- Uses a binary-step search, one stage per cycle: 8, 4, 2, 1.
- Sits in front of the barrel shifter or FP/priority logic. The returned count can be fed back to the shifter to denormalise.

Parameters:
- WIDTH, 16, data width. Only 16 is supported; the stage schedule is fixed at 8, 4, 2, 1.
- CNT_W, 4, width of the shift-count output (log2 WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_data  in  16  word to normalise.
- dir  in  1  1 = left (count leading zeros); 0 = right, logical (count trailing zeros).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  16  normalised word.
- out_count  out  4  number of bit positions shifted.
- out_zero  out  1  in_data was 0x0000.

Behaviour:
- Clock and reset: single clock domain. Async active-high reset forces state to IDLE, in_ready=1, out_valid=0, out_data=0x0000, out_count=0, out_zero=0. Internal working and count registers clear to 0.
- States: IDLE, NORM, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid & in_ready at a rising edge: capture in_data into the working register, latch dir, clear count, set stage index k=3, go to NORM.
- NORM:
  - in_ready=0. in_valid is ignored and in_data is not sampled.
  - At each edge, with s = 2^k:
    - Left mode: if working[15:16-s] are all zero, shift working left by s with zero fill and set count[k]=1.
    - Right mode: if working[s-1:0] are all zero, shift working right logically by s with zero fill and set count[k]=1.
    - Otherwise working and count[k] are unchanged.
    - Then decrement k.
  - The stage with k=0 is the last. Its edge also loads out_data/out_count/out_zero and moves to DONE.
- Latency: exactly 4 edges after the acceptance edge, out_valid=1.
- DONE:
  - out_valid=1. Outputs are held stable until out_valid & out_ready at an edge; then out_valid=0 and the block returns to IDLE.
  - in_ready=0 throughout DONE.
  - Throughput is one result per 6 cycles when out_ready is held high (accept, 4x NORM, DONE).
- Zero input: every stage shifts, so out_count=15, out_data=0x0000, out_zero=1 in both directions.
- Already-normalised input: 0x8000 in left mode, or 0x0001 in right mode, gives out_count=0 and out_data equal to the input.
- Invariant: for nonzero input, out_data[15]=1 in left mode and out_data[0]=1 in right mode.
- Invariant: out_data equals in_data shifted by out_count in the chosen direction, with no lost set bits.
- dir changes after acceptance have no effect on an operation in flight.
- Reset asserted in NORM or DONE aborts the operation immediately; no result is ever emitted for it. The first request after reset is processed normally.
- out_ready asserted outside DONE is ignored.

Test Plan:
- Left mode, in_data=0x0001 accepted at edge E0 -> out_valid rises after edge E4; out_data=0x8000, out_count=15, out_zero=0.
- Left mode, in_data=0x0F00 -> out_data=0xF000, out_count=4. Right mode, same data -> out_data=0x000F, out_count=8.
- in_data=0x0000, either dir -> out_data=0x0000, out_count=15, out_zero=1. Left-mode 0x8000 -> out_count=0, out_data=0x8000.
- Backpressure: in DONE hold out_ready=0 for 3 cycles while driving in_valid=1 with 0x1234 -> outputs stable, in_ready=0, 0x1234 not accepted. Then out_ready=1 -> IDLE next cycle; 0x1234 is accepted in IDLE. Left mode -> out_data=0x91A0, out_count=3.
- Reset pulse asynchronously during the 2nd NORM cycle -> out_valid=0 and in_ready=1 without waiting for a clock edge. The next request (right mode, 0x0040) -> out_data=0x0001, out_count=6.
- Randomised sweep of 1000 words, both dirs -> check both invariants and out_count equals the leading/trailing zero count computed by the bench model.

Source files
------------

// File: rtl/normalize_16bit.sv
// normalize_16bit: sequential normaliser that finds the shift needed to move the
// first set bit to the MSB (left mode) or LSB (right mode). The search is a binary
// step sequence of 8, 4, 2, 1 positions, one stage per clock. The returned count
// can be fed back to the barrel shifter to denormalise.
module normalize_16bit #(
  parameter int WIDTH = 16,  // only 16 is supported: the stage schedule is fixed
  parameter int CNT_W = 4    // log2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   work;       // word being normalised
  logic [CNT_W-1:0]   cnt;        // shift count accumulated so far
  logic [1:0]         k;          // stage index: step size is 2^k
  logic               dir_r;      // direction latched at acceptance
  logic               hit;        // current stage shifts
  logic [3:0]         shift_amt;  // 2^k
  logic [WIDTH-1:0]   stage_word; // work after the current stage
  logic [CNT_W-1:0]   stage_cnt;  // cnt after the current stage

  logic accept;
  logic retire;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples the
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: accept in IDLE, run four stages, hold result until retired.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = NORM;
      NORM:    if (k == 2'd0) next_state = DONE;
      DONE:    if (retire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // One search stage: test whether the outermost 2^k bits on the target side are
  // clear and, if so, shift them out with zero fill.
  always_comb begin
    hit = 1'b0;
    case (k)
      2'd3:    hit = dir_r ? (work[15:8]  == 8'h00) : (work[7:0] == 8'h00);
      2'd2:    hit = dir_r ? (work[15:12] == 4'h0)  : (work[3:0] == 4'h0);
      2'd1:    hit = dir_r ? (work[15:14] == 2'b00) : (work[1:0] == 2'b00);
      default: hit = dir_r ? ~work[15]              : ~work[0];
    endcase
    shift_amt  = 4'd1 << k;
    stage_word = work;
    if (hit) stage_word = dir_r ? (work << shift_amt) : (work >> shift_amt);
    stage_cnt    = cnt;
    stage_cnt[k] = hit;
  end

  // Datapath: capture on acceptance, step during NORM, load outputs on the last stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work      <= '0;
      cnt       <= '0;
      k         <= 2'd0;
      dir_r     <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work  <= in_data;
            dir_r <= dir;
            cnt   <= '0;
            k     <= 2'd3;
          end
        end
        NORM: begin
          work <= stage_word;
          cnt  <= stage_cnt;
          k    <= k - 2'd1;
          if (k == 2'd0) begin
            out_data  <= stage_word;
            out_count <= stage_cnt;
            // Only an all-zero input leaves nothing after every stage has run.
            out_zero  <= (stage_word == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_normalize_16bit.sv
// tb_normalize_16bit: directed and swept checks of the 16-bit normaliser.
module tb_normalize_16bit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        dir;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_count;
  logic        out_zero;

  int n_pass  = 0;
  int n_total = 0;

  normalize_16bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .dir       (dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: leading (left) or trailing (right) zero count; 15 for zero input.
  function automatic int ref_count(input logic [15:0] d, input logic dr);
    int n = 0;
    if (d == 16'h0000) return 15;
    if (dr) begin
      for (int i = 15; i >= 0; i--) begin
        if (d[i]) break;
        n++;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (d[i]) break;
        n++;
      end
    end
    return n;
  endfunction

  // Submit one request and wait for its result; lat is -1 if none appeared.
  // dir is flipped right after acceptance to show it does not affect the operation.
  task automatic run_op(input logic [15:0] d, input logic dr, output int lat);
    int waited = 0;
    lat = -1;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    in_data  = d;
    dir      = dr;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dir      = ~dr;
    in_data  = 16'hDEAD;
    for (int i = 1; i <= 10; i++) begin
      if (out_valid) break;
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic retire_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; dir = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL reset_handshake: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    else n_pass++;
    n_total++;
    if (out_data !== 16'h0 || out_count !== 4'h0 || out_zero !== 1'b0)
      $display("FAIL reset_outputs: data=%h count=%0d zero=%b, want 0000 0 0", out_data, out_count, out_zero);
    else n_pass++;
  endtask

  task automatic test_latency();
    int lat;
    run_op(16'h0001, 1'b1, lat);
    n_total++;
    if (lat !== 4) $display("FAIL latency: got %0d edges, want 4", lat);
    else n_pass++;
    n_total++;
    if (out_data !== 16'h8000 || out_count !== 4'd15 || out_zero !== 1'b0)
      $display("FAIL left_0001: data=%h count=%0d zero=%b, want 8000 15 0", out_data, out_count, out_zero);
    else n_pass++;
    retire_result();
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL retire: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [15:0] vd [6] = '{16'h0F00, 16'h0F00, 16'h0000, 16'h0000, 16'h8000, 16'h0001};
    logic        vr [6] = '{1'b1,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0};
    logic [15:0] ed [6] = '{16'hF000, 16'h000F, 16'h0000, 16'h0000, 16'h8000, 16'h0001};
    logic [3:0]  ec [6] = '{4'd4,     4'd8,     4'd15,    4'd15,    4'd0,     4'd0};
    logic        ez [6] = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0,     1'b0};
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(vd[i], vr[i], lat);
      n_total++;
      if (lat !== 4 || out_data !== ed[i] || out_count !== ec[i] || out_zero !== ez[i])
        $display("FAIL directed[%0d] in=%h dir=%b: lat=%0d data=%h count=%0d zero=%b, want 4 %h %0d %b",
                 i, vd[i], vr[i], lat, out_data, out_count, out_zero, ed[i], ec[i], ez[i]);
      else n_pass++;
      retire_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [15:0] held_data;
    logic [3:0]  held_cnt;
    run_op(16'h0300, 1'b0, lat);
    held_data = out_data;
    held_cnt  = out_count;
    n_total++;
    if (lat !== 4 || held_data !== 16'h0003 || held_cnt !== 4'd8)
      $display("FAIL bp_first: lat=%0d data=%h count=%0d, want 4 0003 8", lat, held_data, held_cnt);
    else n_pass++;
    in_data = 16'h1234; dir = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 16'h0003 || out_count !== 4'd8)
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b data=%h count=%0d, want 1 0 0003 8",
                 i, out_valid, in_ready, out_data, out_count);
      else n_pass++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL bp_accept: in_ready=%b, want 0", in_ready);
    else n_pass++;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    n_total++;
    if (lat !== 4 || out_data !== 16'h91A0 || out_count !== 4'd3 || out_zero !== 1'b0)
      $display("FAIL bp_second: lat=%0d data=%h count=%0d zero=%b, want 4 91a0 3 0", lat, out_data, out_count, out_zero);
    else n_pass++;
    retire_result();
  endtask

  task automatic test_abort();
    int lat;
    in_data = 16'h0100; dir = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);   // second NORM cycle begins
    #3 rst = 1'b1;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL abort_async: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL abort_no_result: out_valid=%b, want 0", out_valid);
      else n_pass++;
    end
    run_op(16'h0040, 1'b0, lat);
    n_total++;
    if (lat !== 4 || out_data !== 16'h0001 || out_count !== 4'd6 || out_zero !== 1'b0)
      $display("FAIL after_abort: lat=%0d data=%h count=%0d zero=%b, want 4 0001 6 0", lat, out_data, out_count, out_zero);
    else n_pass++;
    retire_result();
  endtask

  task automatic test_sweep();
    int lat;
    int ec;
    logic [15:0] d;
    logic [15:0] ed;
    logic        dr;
    for (int i = 0; i < 1000; i++) begin
      d  = 16'($urandom) >> $urandom_range(0, 15);
      dr = i[0];
      ec = ref_count(d, dr);
      ed = (d == 16'h0) ? 16'h0 : (dr ? (d << ec) : (d >> ec));
      run_op(d, dr, lat);
      n_total++;
      if (lat !== 4 || out_data !== ed || out_count !== 4'(ec) || out_zero !== (d == 16'h0))
        $display("FAIL sweep[%0d] in=%h dir=%b: lat=%0d data=%h count=%0d zero=%b, want 4 %h %0d %b",
                 i, d, dr, lat, out_data, out_count, out_zero, ed, ec, (d == 16'h0));
      else n_pass++;
      n_total++;
      if (d != 16'h0 && (dr ? out_data[15] : out_data[0]) !== 1'b1)
        $display("FAIL sweep_edge_bit[%0d] in=%h dir=%b: data=%h, want set bit at the target edge", i, d, dr, out_data);
      else n_pass++;
      retire_result();
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_abort();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
